pwm_multichannel_driver: RTL

Parametrised successor to the team's fixed 8-channel, 3-bit PWM driver. It drives CHANNELS PWM outputs at LEVEL_BITS duty resolution and adds three things: double-buffered duty registers with a glitch-free commit at the period boundary, an optional per-channel phase-staggered mode, and a configurable output polarity. It sits directly behind the chip I/O wrapper. The host loads duties through a simple write strobe and then commits them all at once.

---
 rtl/pwm_multichannel_driver.sv | 84 ++++++++
 1 files changed

// File: rtl/pwm_multichannel_driver.sv
// Multi-channel PWM driver. Duty values are written into shadow registers and
// moved to the active registers together at the end of a period.
module pwm_multichannel_driver #(
  parameter int CHANNELS   = 8,
  parameter int LEVEL_BITS = 4,
  parameter int ADDR_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter bit OUT_INVERT = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_BITS-1:0]  wr_addr,
  input  logic [LEVEL_BITS-1:0] wr_level,
  input  logic                  commit,
  input  logic                  stagger,
  output logic [CHANNELS-1:0]   pwm_out,
  output logic                  period_start,
  output logic                  commit_pending
);

  localparam logic [LEVEL_BITS-1:0] CNT_MAX = '1;

  logic [LEVEL_BITS-1:0] r_cnt;
  logic                  r_pending;
  logic                  w_transfer;
  logic [CHANNELS-1:0]   w_pwm_next;

  // A commit arriving on the last cycle of a period transfers immediately.
  assign w_transfer     = (r_cnt == CNT_MAX) && (r_pending || commit);
  assign commit_pending = r_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_pending    <= 1'b0;
      period_start <= 1'b0;
    end else begin
      r_cnt        <= r_cnt + LEVEL_BITS'(1);
      period_start <= (r_cnt == '0);
      if (w_transfer) begin
        r_pending <= 1'b0;
      end else if (commit) begin
        r_pending <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    localparam logic [LEVEL_BITS-1:0] PHASE_OFFS = LEVEL_BITS'(gi);

    logic                  w_sel;
    logic [LEVEL_BITS-1:0] w_shadow_next;
    logic [LEVEL_BITS-1:0] w_phase;
    logic [LEVEL_BITS-1:0] r_shadow;
    logic [LEVEL_BITS-1:0] r_active;

    // Addresses at or above CHANNELS match no channel and are dropped.
    assign w_sel         = wr_en && (wr_addr == ADDR_BITS'(gi));
    assign w_shadow_next = w_sel ? wr_level : r_shadow;
    assign w_phase       = stagger ? (r_cnt + PHASE_OFFS) : r_cnt;
    assign w_pwm_next[gi] = (w_phase < r_active) ^ OUT_INVERT;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_shadow <= '0;
        r_active <= '0;
      end else begin
        r_shadow <= w_shadow_next;
        if (w_transfer) begin
          r_active <= w_shadow_next;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= {CHANNELS{OUT_INVERT}};
    end else begin
      pwm_out <= w_pwm_next;
    end
  end

endmodule
